// File: rtl/busctl_pkg.sv
// Shared types and sizing constants for the half-duplex bus controller.
package busctl_pkg;

    localparam int BUSCTL_WIDTH_DFLT = 16;
    localparam int TURN_CNT_W        = 4;
    localparam int BURST_CNT_W       = 8;

    typedef enum logic [1:0] {
        RX      = 2'd0,
        TURN_TX = 2'd1,
        TX      = 2'd2,
        TURN_RX = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bus_halfduplex_ctrl_if.sv
// Signal bundle between the bus controller (master) and its TX/RX/pad environment (slave).
interface bus_halfduplex_ctrl_if
    import busctl_pkg::*;
#(
    parameter int WIDTH = BUSCTL_WIDTH_DFLT
);
    // Handshakes: a transfer happens on a cycle where valid && ready are both high;
    // valid never waits on ready, and data is stable whenever valid is high.
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic             bus_oe;
    logic             bus_tx_strobe;
    logic             ext_req;
    logic             ext_grant;
    logic             ext_strobe;
    logic             rx_overrun;
    logic             bus_err;
`ifdef BUSCTL_OVERRUN_CNT_EN
    logic [15:0]      ovr_count;
`endif

    modport master (
        input  tx_data, tx_valid, rx_ready, bus_in, ext_req, ext_strobe,
        output tx_ready, rx_data, rx_valid, bus_out, bus_oe, bus_tx_strobe,
`ifdef BUSCTL_OVERRUN_CNT_EN
        output ovr_count,
`endif
        output ext_grant, rx_overrun, bus_err
    );

    modport slave (
        output tx_data, tx_valid, rx_ready, bus_in, ext_req, ext_strobe,
        input  tx_ready, rx_data, rx_valid, bus_out, bus_oe, bus_tx_strobe,
`ifdef BUSCTL_OVERRUN_CNT_EN
        input  ovr_count,
`endif
        input  ext_grant, rx_overrun, bus_err
    );

endinterface

// File: rtl/busctl_rx_hold.sv
// Single-entry RX holding register; a load that finds the slot full and not draining is dropped.
module busctl_rx_hold
    import busctl_pkg::*;
#(
    parameter int WIDTH = BUSCTL_WIDTH_DFLT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_overrun
);

    logic accept;

    // A consume in the same cycle frees the slot for the incoming word.
    assign accept = load && (!rx_valid || rx_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= load && !accept;
            if (accept) begin
                rx_data  <= din;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_halfduplex_ctrl.sv
// Half-duplex shared-bus direction controller with turnaround gaps and bounded TX bursts.
// Optional saturating overrun counter (ovr_count) when BUSCTL_OVERRUN_CNT_EN is defined.
module bus_halfduplex_ctrl
    import busctl_pkg::*;
#(
    parameter int WIDTH        = BUSCTL_WIDTH_DFLT,
    parameter int TURN_CYCLES  = 2,
    parameter int TX_MAX_BURST = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bus_halfduplex_ctrl_if.master bif,
    output state_t                dbg_state
);

    localparam logic [TURN_CNT_W-1:0]  TURN_LAST = TURN_CNT_W'(TURN_CYCLES - 1);
    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(TX_MAX_BURST);

    state_t                 state, state_nxt;
    logic [TURN_CNT_W-1:0]  turn_cnt, turn_cnt_nxt;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic [WIDTH-1:0]       bus_out_q;
    logic                   strobe_q;
    logic                   bus_err_q;
    logic                   tx_ready_c;
    logic                   tx_fire;
    logic                   bus_oe_c;
    logic                   ext_grant_c;
    logic                   capture;
    logic [WIDTH-1:0]       rx_data_w;
    logic                   rx_valid_w;
    logic                   rx_overrun_w;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RX;
            turn_cnt  <= '0;
            burst_cnt <= '0;
            bus_out_q <= '0;
            strobe_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            turn_cnt  <= turn_cnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            strobe_q  <= tx_fire;
            bus_err_q <= bif.ext_strobe && !ext_grant_c;
            if (tx_fire) begin
                bus_out_q <= bif.tx_data;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        turn_cnt_nxt  = turn_cnt;
        burst_cnt_nxt = burst_cnt;
        tx_ready_c    = 1'b0;
        tx_fire       = 1'b0;
        bus_oe_c      = 1'b0;
        ext_grant_c   = 1'b0;
        case (state)
            RX: begin
                ext_grant_c = 1'b1;
                if (bif.tx_valid && !bif.ext_req) begin
                    state_nxt    = TURN_TX;
                    turn_cnt_nxt = '0;
                end
            end
            TURN_TX: begin
                if (turn_cnt == TURN_LAST) begin
                    state_nxt     = TX;
                    turn_cnt_nxt  = '0;
                    burst_cnt_nxt = '0;
                end else begin
                    turn_cnt_nxt = turn_cnt + 1'b1;
                end
            end
            TX: begin
                bus_oe_c   = 1'b1;
                // An external request only cuts a burst once at least one word has gone out.
                tx_ready_c = (burst_cnt < BURST_MAX) && !(bif.ext_req && (burst_cnt != '0));
                tx_fire    = tx_ready_c && bif.tx_valid;
                if (tx_fire) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end else begin
                    // Leaving only on an idle cycle keeps the last word driven a full cycle.
                    state_nxt    = TURN_RX;
                    turn_cnt_nxt = '0;
                end
            end
            TURN_RX: begin
                if (turn_cnt == TURN_LAST) begin
                    state_nxt    = RX;
                    turn_cnt_nxt = '0;
                end else begin
                    turn_cnt_nxt = turn_cnt + 1'b1;
                end
            end
            default: state_nxt = RX;
        endcase
    end

    assign capture = ext_grant_c && bif.ext_strobe;

    busctl_rx_hold #(.WIDTH(WIDTH)) u_rx_hold (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (capture),
        .din        (bif.bus_in),
        .rx_ready   (bif.rx_ready),
        .rx_data    (rx_data_w),
        .rx_valid   (rx_valid_w),
        .rx_overrun (rx_overrun_w)
    );

`ifdef BUSCTL_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovr_cnt_q <= '0;
        end else if (rx_overrun_w) begin
            ovr_cnt_q <= sat_inc16(ovr_cnt_q);
        end
    end

    assign bif.ovr_count = ovr_cnt_q;
`endif

    assign bif.tx_ready      = tx_ready_c;
    assign bif.bus_oe        = bus_oe_c;
    assign bif.ext_grant     = ext_grant_c;
    assign bif.bus_out       = bus_out_q;
    assign bif.bus_tx_strobe = strobe_q;
    assign bif.bus_err       = bus_err_q;
    assign bif.rx_data       = rx_data_w;
    assign bif.rx_valid      = rx_valid_w;
    assign bif.rx_overrun    = rx_overrun_w;
    assign dbg_state         = state;

endmodule

// File: tb/tb_bus_halfduplex_ctrl.sv
// Directed bench for bus_halfduplex_ctrl: RX vector table plus TX burst / turnaround sequences.
module tb_bus_halfduplex_ctrl;
    import busctl_pkg::*;

    logic   clock;
    logic   reset_n;
    state_t dbg_state;

    bus_halfduplex_ctrl_if #(.WIDTH(16)) bif ();

    bus_halfduplex_ctrl #(.WIDTH(16), .TURN_CYCLES(2), .TX_MAX_BURST(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bif       (bif),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic fired = 1'b0;
    int run_len = 0;
    int bursts_done = 0;
    int exp_burst = 0;

    typedef struct {
        logic        stb;
        logic [15:0] bin;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_ovr;
        logic [15:0] exp_cnt;
    } rx_vec_t;

    rx_vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // scoreboard + per-cycle invariants, sampled at the falling edge
    task automatic sample_check();
        chk("oe_and_grant_exclusive", {31'd0, bif.bus_oe && bif.ext_grant}, 32'd0);
        if (bif.bus_tx_strobe) begin
            run_len++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_word unexpected strobe got %h want none", bif.bus_out);
            end else begin
                chk("tx_word", {16'd0, bif.bus_out}, {16'd0, exp_q.pop_front()});
            end
        end else if (run_len != 0) begin
            bursts_done++;
            if (exp_burst != 0) chk("burst_len", run_len, exp_burst);
            run_len = 0;
        end
    endtask

    // driver: one clock cycle of TX/RX stimulus
    task automatic cyc(input logic v, input logic req, input logic stb, input logic [15:0] bin);
        @(negedge clock);
        sample_check();
        if (fired) bif.tx_data = bif.tx_data + 16'd1;
        bif.tx_valid   = v;
        bif.ext_req    = req;
        bif.ext_strobe = stb;
        bif.bus_in     = bin;
        #1;
        fired = bif.tx_valid && bif.tx_ready;
        if (fired) exp_q.push_back(bif.tx_data);
    endtask

    int b0;

    initial begin
        vecs[0] = '{1'b1, 16'hA5A5, 1'b1, 1'b1, 16'hA5A5, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA5A5, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h1234, 1'b1, 16'd0};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 16'd1};
        vecs[5] = '{1'b1, 16'hCAFE, 1'b1, 1'b1, 16'hCAFE, 1'b0, 16'd1};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hCAFE, 1'b0, 16'd1};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'hCAFE, 1'b0, 16'd1};

        reset_n        = 1'b0;
        bif.tx_data    = '0;
        bif.tx_valid   = 1'b0;
        bif.rx_ready   = 1'b1;
        bif.bus_in     = '0;
        bif.ext_req    = 1'b0;
        bif.ext_strobe = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_bus_oe",     {31'd0, bif.bus_oe}, 32'd0);
        chk("rst_bus_out",    {16'd0, bif.bus_out}, 32'd0);
        chk("rst_strobe",     {31'd0, bif.bus_tx_strobe}, 32'd0);
        chk("rst_rx_valid",   {31'd0, bif.rx_valid}, 32'd0);
        chk("rst_rx_data",    {16'd0, bif.rx_data}, 32'd0);
        chk("rst_rx_overrun", {31'd0, bif.rx_overrun}, 32'd0);
        chk("rst_bus_err",    {31'd0, bif.bus_err}, 32'd0);
        chk("rst_tx_ready",   {31'd0, bif.tx_ready}, 32'd0);
        chk("rst_ext_grant",  {31'd0, bif.ext_grant}, 32'd1);
        chk("rst_state",      {30'd0, dbg_state}, {30'd0, RX});
        reset_n = 1'b1;

        // RX capture table (idle RX state, grant held)
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            bif.ext_strobe = vecs[i].stb;
            bif.bus_in     = vecs[i].bin;
            bif.rx_ready   = vecs[i].rdy;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_rx_valid", i), {31'd0, bif.rx_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_rx_data", i), {16'd0, bif.rx_data}, {16'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_overrun", i), {31'd0, bif.rx_overrun}, {31'd0, vecs[i].exp_ovr});
            chk($sformatf("vec%0d_bus_oe", i), {31'd0, bif.bus_oe}, 32'd0);
            chk($sformatf("vec%0d_grant", i), {31'd0, bif.ext_grant}, 32'd1);
`ifdef BUSCTL_OVERRUN_CNT_EN
            chk($sformatf("vec%0d_ovr_count", i), {16'd0, bif.ovr_count}, {16'd0, vecs[i].exp_cnt});
`endif
        end
        bif.ext_strobe = 1'b0;
        bif.rx_ready   = 1'b1;

        // three-word burst with exact turnaround timing
        exp_burst   = 3;
        bif.tx_data = 16'h0001;
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("a_turn_tx_oe", {31'd0, bif.bus_oe}, 32'd0);
        chk("a_turn_tx_grant", {31'd0, bif.ext_grant}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("a_turn_tx2_oe", {31'd0, bif.bus_oe}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("a_tx_oe_rise", {31'd0, bif.bus_oe}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("a_last_word_oe", {31'd0, bif.bus_oe}, 32'd1);
        chk("a_last_word_strobe", {31'd0, bif.bus_tx_strobe}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("a_oe_fall", {31'd0, bif.bus_oe}, 32'd0);
        chk("a_strobe_fall", {31'd0, bif.bus_tx_strobe}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("a_turn_rx_grant", {31'd0, bif.ext_grant}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("a_grant_back", {31'd0, bif.ext_grant}, 32'd1);

        // continuous tx_valid: two full 8-word bursts in 28 cycles
        exp_burst   = 8;
        b0          = bursts_done;
        bif.tx_data = 16'h0100;
        repeat (28) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("b_bursts", bursts_done - b0, 32'd2);
        chk("b_back_in_rx", {30'd0, dbg_state}, {30'd0, RX});

        // ext_req after word 2 cuts the burst and holds the bus in RX
        exp_burst   = 2;
        b0          = bursts_done;
        bif.tx_data = 16'h0200;
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        chk("c_tx_ready_drop", {31'd0, bif.tx_ready}, 32'd0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 16'h0);
            chk($sformatf("c_hold_rx%0d", i), {30'd0, dbg_state}, {30'd0, RX});
        end
        chk("c_grant", {31'd0, bif.ext_grant}, 32'd1);
        chk("c_bursts", bursts_done - b0, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);

        // hold an RX word, then ext_strobe during TX, then async reset mid-TX
        bif.rx_ready = 1'b0;
        exp_burst    = 8;
        cyc(1'b0, 1'b0, 1'b1, 16'h5A5A);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("d_rx_held", {31'd0, bif.rx_valid}, 32'd1);
        bif.tx_data = 16'h0300;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b1, 16'hDEAD);
        chk("d_in_tx", {30'd0, dbg_state}, {30'd0, TX});
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("d_bus_err", {31'd0, bif.bus_err}, 32'd1);
        chk("d_no_capture", {16'd0, bif.rx_data}, 32'h5A5A);
        chk("d_no_overrun", {31'd0, bif.rx_overrun}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("d_bus_err_pulse", {31'd0, bif.bus_err}, 32'd0);
        chk("d_oe_pre_reset", {31'd0, bif.bus_oe}, 32'd1);
        #2;
        reset_n      = 1'b0;
        bif.tx_valid = 1'b0;
        #1;
        chk("d_rst_oe", {31'd0, bif.bus_oe}, 32'd0);
        chk("d_rst_state", {30'd0, dbg_state}, {30'd0, RX});
        chk("d_rst_grant", {31'd0, bif.ext_grant}, 32'd1);
        chk("d_rst_rx_valid", {31'd0, bif.rx_valid}, 32'd0);
        fired = 1'b0;
        run_len = 0;
        exp_q.delete();
        @(negedge clock);
        reset_n      = 1'b1;
        bif.rx_ready = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("d_post_state", {30'd0, dbg_state}, {30'd0, RX});
        chk("d_post_strobe", {31'd0, bif.bus_tx_strobe}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
